// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Constants only; no logic, no latency, no flow control.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversample tick and serial line in, byte/strobes/busy out.
// Strobes are fire-and-forget; the consumer (RX FIFO write side) has no backpressure.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic                 rx_en;
  logic                 rx_serial_data;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_data_valid;
  logic                 rx_frame_err;
  logic                 rx_busy;

  modport master (
    output rx_en,
    output rx_serial_data,
    input  rx_data_out,
    input  rx_data_valid,
    input  rx_frame_err,
    input  rx_busy
  );

  modport slave (
    input  rx_en,
    input  rx_serial_data,
    output rx_data_out,
    output rx_data_valid,
    output rx_frame_err,
    output rx_busy
  );

endinterface

// File: rtl/uart_sync.sv
// Single-bit synchroniser for the asynchronous serial line, presets to idle-high.
// Latency SYNC_STAGES clk_in cycles; no flow control.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/data/stop framing, one-cycle valid or framing-error strobe.
// Strobe lands 1 clk_in after the mid-stop-bit rx_en tick; no backpressure, consumer must take it.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk_in,
  input  logic     rst,
  uart_rx_if.slave rx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 busy_q;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (rx.rx_serial_data),
    .dout   (rxs)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= RX_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (rx.rx_en) begin
        unique case (state)
          RX_IDLE: begin
            if (!rxs) begin
              state    <= RX_START;
              tick_cnt <= '0;
              busy_q   <= 1'b1;
            end
          end
          RX_START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              // Line back high at mid start bit: treat as a glitch.
              if (!rxs) begin
                state   <= RX_DATA;
                bit_cnt <= '0;
              end else begin
                state  <= RX_IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          RX_DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shift    <= {rxs, shift[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_BIT) begin
                state <= RX_STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          RX_STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              // Leave at mid stop bit so a back-to-back start edge is not missed.
              if (rxs) begin
                data_q  <= shift;
                valid_q <= 1'b1;
                state   <= RX_IDLE;
                busy_q  <= 1'b0;
              end else begin
                err_q <= 1'b1;
                state <= RX_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          RX_BREAK: begin
            if (rxs) begin
              state  <= RX_IDLE;
              busy_q <= 1'b0;
            end
          end
          default: begin
            state  <= RX_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.rx_data_out   = data_q;
  assign rx.rx_data_valid = valid_q;
  assign rx.rx_frame_err  = err_q;
  assign rx.rx_busy       = busy_q;

endmodule
